// File: rtl/cpu_trace_fifo.sv
// CPU bus trace FIFO: turns completed rd/wr strobes and halt edges into 26-bit trace records
// and buffers them for a ready/valid consumer, with sticky overflow and saturating drop count.
module cpu_trace_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rd,
  input  logic        wr,
  input  logic        fetch,
  input  logic        halt,
  input  logic [2:0]  opcode,
  input  logic [12:0] addr,
  input  logic [7:0]  data,
  input  logic        clr_ovf,
  input  logic        trace_ready,
  output logic        trace_valid,
  output logic [25:0] trace_data,
  output logic [6:0]  count,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          r_rd_q, r_wr_q, r_halt_q;
  logic [12:0]   r_cap_addr;
  logic [7:0]    r_cap_data;
  logic [2:0]    r_cap_op;
  logic          r_cap_fetch;
  logic          r_halt_pend;
  logic [25:0]   r_halt_rec;
  logic [25:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [6:0]    r_count;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic          w_access_end, w_halt_edge;
  logic [1:0]    w_acc_type;
  logic          w_push, w_set_pend;
  logic [25:0]   w_push_rec;
  logic          w_full, w_pop, w_wr_en, w_drop;

  assign w_access_end = (r_rd_q | r_wr_q) & ~(rd | wr);
  assign w_halt_edge  = halt & ~r_halt_q;
  assign w_acc_type   = r_wr_q ? 2'b10 : (r_cap_fetch ? 2'b00 : 2'b01);

  // A deferred halt marker always goes first; a halt edge that coincides with an access end
  // is parked in r_halt_rec so the access record keeps its place in the stream.
  always_comb begin
    w_push     = 1'b0;
    w_push_rec = '0;
    w_set_pend = 1'b0;
    if (enable) begin
      if (r_halt_pend) begin
        w_push     = 1'b1;
        w_push_rec = r_halt_rec;
      end else if (w_access_end) begin
        w_push     = 1'b1;
        w_push_rec = {w_acc_type, r_cap_op, r_cap_addr, r_cap_data};
        w_set_pend = w_halt_edge;
      end else if (w_halt_edge) begin
        w_push     = 1'b1;
        w_push_rec = {2'b11, opcode, addr, data};
      end
    end
  end

  assign trace_valid = (r_count != 7'd0);
  assign trace_data  = trace_valid ? r_mem[r_rptr] : '0;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

  assign w_full  = (r_count == 7'(DEPTH));
  assign w_pop   = trace_valid & trace_ready;
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_q      <= 1'b0;
      r_wr_q      <= 1'b0;
      r_halt_q    <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_data  <= '0;
      r_cap_op    <= '0;
      r_cap_fetch <= 1'b0;
      r_halt_pend <= 1'b0;
      r_halt_rec  <= '0;
    end else begin
      r_rd_q      <= rd;
      r_wr_q      <= wr;
      r_halt_q    <= halt;
      r_halt_pend <= w_set_pend;
      if (rd | wr) begin
        r_cap_addr  <= addr;
        r_cap_data  <= data;
        r_cap_op    <= opcode;
        r_cap_fetch <= fetch;
      end
      if (w_set_pend) begin
        r_halt_rec <= {2'b11, opcode, addr, data};
      end
    end
  end

  // Storage is not reset; trace_data is gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= w_push_rec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf wins: the counter restarts at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Directed bench for cpu_trace_fifo: access capture, halt markers, overflow, clear and reset.
module tb_cpu_trace_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, fetch = 1'b0, halt = 1'b0;
  logic [2:0]  opcode = '0;
  logic [12:0] addr = '0;
  logic [7:0]  data = '0;
  logic        clr_ovf = 1'b0, trace_ready = 1'b0;
  logic        trace_valid;
  logic [25:0] trace_data;
  logic [6:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  cpu_trace_fifo #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rd          (rd),
    .wr          (wr),
    .fetch       (fetch),
    .halt        (halt),
    .opcode      (opcode),
    .addr        (addr),
    .data        (data),
    .clr_ovf     (clr_ovf),
    .trace_ready (trace_ready),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .count       (count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] rec(input logic [1:0] t, input logic [2:0] op,
                                      input logic [12:0] a, input logic [7:0] d);
    return {t, op, a, d};
  endfunction

  // One-cycle read strobe; its record is pushed on the second edge.
  task automatic do_read(input logic [12:0] a, input logic [7:0] d, input logic [2:0] op,
                         input logic f);
    rd = 1'b1; addr = a; data = d; opcode = op; fetch = f;
    tick();
    rd = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(trace_valid), 32'd0);
    chk({tag, "_data"},  32'(trace_data),  32'd0);
    chk({tag, "_count"}, 32'(count),       32'd0);
    chk({tag, "_ovf"},   32'(overflow),    32'd0);
    chk({tag, "_drop"},  32'(drop_cnt),    32'd0);
  endtask

  initial begin
    #2;
    chk_all_zero("reset");
    tick(); tick();
    rst = 1'b1; enable = 1'b1;
    tick();

    // Two-cycle fetch read
    rd = 1'b1; fetch = 1'b1; addr = 13'h0001; data = 8'hA0; opcode = 3'b101;
    tick(); tick();
    rd = 1'b0; addr = 13'h0AAA; data = 8'h00; opcode = 3'b000; fetch = 1'b0;
    tick();
    chk("rd_valid", 32'(trace_valid), 32'd1);
    chk("rd_data",  32'(trace_data),  32'(rec(2'b00, 3'b101, 13'h0001, 8'hA0)));
    chk("rd_count", 32'(count),       32'd1);
    trace_ready = 1'b1;
    tick();
    chk("rd_popped", 32'(count), 32'd0);

    // Write pulse with consumer ready
    wr = 1'b1; addr = 13'h1802; data = 8'h55; opcode = 3'b011;
    tick();
    wr = 1'b0;
    tick();
    chk("wr_count", 32'(count),      32'd1);
    chk("wr_data",  32'(trace_data), 32'(rec(2'b10, 3'b011, 13'h1802, 8'h55)));
    tick();
    chk("wr_popped", 32'(count), 32'd0);

    // Ten reads into an eight-deep FIFO with no consumer
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_read(13'(32'h100 + i), 8'(32'h10 + i), 3'(i), i[0]);
    end
    chk("ovf_count", 32'(count),    32'd8);
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(trace_data),
          32'(rec(i[0] ? 2'b00 : 2'b01, 3'(i), 13'(32'h100 + i), 8'(32'h10 + i))));
      tick();
    end
    trace_ready = 1'b0;
    chk("drain_empty", 32'(count),    32'd0);
    chk("drain_valid", 32'(trace_valid), 32'd0);
    chk("ovf_sticky",  32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf",  32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // Read end coincides with halt rising edge
    rd = 1'b1; addr = 13'h00AA; data = 8'h33; opcode = 3'b010; fetch = 1'b0;
    tick();
    rd = 1'b0; halt = 1'b1; addr = 13'h1FFF; data = 8'hEE; opcode = 3'b111;
    tick();
    chk("halt_c1", 32'(count), 32'd1);
    tick();
    chk("halt_c2",   32'(count),      32'd2);
    chk("halt_head", 32'(trace_data), 32'(rec(2'b01, 3'b010, 13'h00AA, 8'h33)));
    trace_ready = 1'b1;
    tick();
    chk("halt_mark", 32'(trace_data), 32'(rec(2'b11, 3'b111, 13'h1FFF, 8'hEE)));
    tick();
    chk("halt_empty", 32'(count), 32'd0);
    trace_ready = 1'b0; halt = 1'b0;
    tick();

    // Push into a full FIFO with a simultaneous pop
    for (int i = 0; i < 8; i++) begin
      do_read(13'(32'h200 + i), 8'(i), 3'b000, 1'b1);
    end
    chk("full_count", 32'(count), 32'd8);
    rd = 1'b1; addr = 13'h02FF; data = 8'hFF; opcode = 3'b001; fetch = 1'b1;
    tick();
    rd = 1'b0; trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    chk("fullpop_count", 32'(count),      32'd8);
    chk("fullpop_ovf",   32'(overflow),   32'd0);
    chk("fullpop_drop",  32'(drop_cnt),   32'd0);
    chk("fullpop_head",  32'(trace_data), 32'(rec(2'b00, 3'b000, 13'h0201, 8'h01)));

    // Drop and clear in the same cycle: the drop wins
    rd = 1'b1; addr = 13'h0300;
    tick();
    rd = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("dropclr_ovf",  32'(overflow), 32'd1);
    chk("dropclr_drop", 32'(drop_cnt), 32'd1);

    // Capture disabled: events vanish without counting as drops
    enable = 1'b0;
    do_read(13'h0400, 8'h40, 3'b100, 1'b0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    enable = 1'b1;
    chk("dis_count", 32'(count),    32'd8);
    chk("dis_drop",  32'(drop_cnt), 32'd1);

    // Asynchronous reset at count 5
    trace_ready = 1'b1;
    tick(); tick(); tick();
    trace_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("post_rst_count", 32'(count),       32'd0);
    chk("post_rst_valid", 32'(trace_valid), 32'd0);
    do_read(13'h0044, 8'h44, 3'b100, 1'b1);
    chk("post_rst_rec",   32'(count),      32'd1);
    chk("post_rst_data",  32'(trace_data), 32'(rec(2'b00, 3'b100, 13'h0044, 8'h44)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
